// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with a start/busy/done handshake and N/Z/C/V flags.
// Defining ALU_SEQ_DECIMAL_EN adds the DADJ state (BCD adjust for ADC/SBC).
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             decimal_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             negative_out,
    output logic             zero_out
);

    localparam logic [OP_W-1:0] OP_OR  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(1);
    localparam logic [OP_W-1:0] OP_EOR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADC = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SBC = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ASL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LSR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ROL = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ROR = OP_W'(8);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(9);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DADJ = 2'd2, DONE = 2'd3} state_t;

    state_t           state_r, state_s;
    logic             exec_ph_r;
    logic             capture_s;
    logic             go_dadj_s;
    logic [OP_W-1:0]  op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             cin_r;
    logic [WIDTH-1:0] stg_res_r;
    logic             stg_c_r, stg_v_r, stg_n_r, stg_z_r;
    logic [WIDTH-1:0] beff_s, bin_res_s, flag_val_s;
    logic [WIDTH:0]   sum_s;
    logic             cin_eff_s, bin_c_s, bin_v_s;

`ifdef ALU_SEQ_DECIMAL_EN
    logic           dec_r;
    logic [WIDTH:0] bcd_s;

    // Nibble-serial BCD add/subtract; returns {carry (no-borrow for SBC), digits}.
    function automatic logic [WIDTH:0] bcd_adjust(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic cin, input logic sub);
        logic             c;
        logic [4:0]       s;
        logic [WIDTH-1:0] r;
        r = '0;
        c = sub ? ~cin : cin;
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (sub) begin
                s = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, c};
                if (s[4]) begin
                    s = s - 5'd6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
            end else begin
                s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
                if (s > 5'd9) begin
                    s = s + 5'd6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
            end
            r[4*i +: 4] = s[3:0];
        end
        return {sub ? ~c : c, r};
    endfunction

    // Decimal result for the DADJ stage.
    always_comb begin
        bcd_s = bcd_adjust(a_r, b_r, cin_r, op_r == OP_SBC);
    end

    assign go_dadj_s = dec_r && ((op_r == OP_ADC) || (op_r == OP_SBC));

    // Decimal-mode flag captured alongside the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_r <= 1'b0;
        end else if (capture_s) begin
            dec_r <= decimal_in;
        end
    end
`else
    logic unused_s;
    assign unused_s  = decimal_in;
    assign go_dadj_s = 1'b0;
`endif

    assign capture_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Binary datapath; SBC and CMP share the adder with B inverted, CMP forces carry-in.
    always_comb begin
        beff_s    = b_r;
        cin_eff_s = cin_r;
        if (op_r == OP_SBC) begin
            beff_s = ~b_r;
        end else if (op_r == OP_CMP) begin
            beff_s    = ~b_r;
            cin_eff_s = 1'b1;
        end else begin
            beff_s = b_r;
        end
        sum_s     = {1'b0, a_r} + {1'b0, beff_s} + {{WIDTH{1'b0}}, cin_eff_s};
        bin_res_s = result;
        bin_c_s   = carry_out;
        bin_v_s   = overflow_out;
        case (op_r)
            OP_OR:  bin_res_s = a_r | b_r;
            OP_AND: bin_res_s = a_r & b_r;
            OP_EOR: bin_res_s = a_r ^ b_r;
            OP_ADC, OP_SBC: begin
                bin_res_s = sum_s[WIDTH-1:0];
                bin_c_s   = sum_s[WIDTH];
                bin_v_s   = (a_r[WIDTH-1] == beff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_ASL: begin
                bin_res_s = {a_r[WIDTH-2:0], 1'b0};
                bin_c_s   = a_r[WIDTH-1];
            end
            OP_LSR: begin
                bin_res_s = {1'b0, a_r[WIDTH-1:1]};
                bin_c_s   = a_r[0];
            end
            OP_ROL: begin
                bin_res_s = {a_r[WIDTH-2:0], cin_r};
                bin_c_s   = a_r[WIDTH-1];
            end
            OP_ROR: begin
                bin_res_s = {cin_r, a_r[WIDTH-1:1]};
                bin_c_s   = a_r[0];
            end
            OP_CMP: bin_c_s = sum_s[WIDTH];
            default: bin_res_s = a_r;
        endcase
        flag_val_s = (op_r == OP_CMP) ? sum_s[WIDTH-1:0] : bin_res_s;
    end

    // Next-state logic; EXEC spans two cycles (adder stage, then flag commit).
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? EXEC : IDLE;
            EXEC:    state_s = exec_ph_r ? (go_dadj_s ? DADJ : DONE) : EXEC;
            DADJ:    state_s = DONE;
            DONE:    state_s = start ? EXEC : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, operand capture, staging and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            exec_ph_r    <= 1'b0;
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            cin_r        <= 1'b0;
            stg_res_r    <= '0;
            stg_c_r      <= 1'b0;
            stg_v_r      <= 1'b0;
            stg_n_r      <= 1'b0;
            stg_z_r      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            negative_out <= 1'b0;
            zero_out     <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == EXEC) || (state_s == DADJ);
            done    <= (state_s == DONE);
            if (capture_s) begin
                op_r      <= op;
                a_r       <= a_in;
                b_r       <= b_in;
                cin_r     <= carry_in;
                exec_ph_r <= 1'b0;
            end else if (state_r == EXEC) begin
                exec_ph_r <= ~exec_ph_r;
            end
            if ((state_r == EXEC) && !exec_ph_r) begin
                stg_res_r <= bin_res_s;
                stg_c_r   <= bin_c_s;
                stg_v_r   <= bin_v_s;
                stg_n_r   <= flag_val_s[WIDTH-1];
                stg_z_r   <= (flag_val_s == {WIDTH{1'b0}});
            end
            if ((state_r == EXEC) && exec_ph_r) begin
                result       <= stg_res_r;
                carry_out    <= stg_c_r;
                overflow_out <= stg_v_r;
                negative_out <= stg_n_r;
                zero_out     <= stg_z_r;
            end
`ifdef ALU_SEQ_DECIMAL_EN
            if (state_r == DADJ) begin
                result       <= bcd_s[WIDTH-1:0];
                carry_out    <= bcd_s[WIDTH];
                negative_out <= bcd_s[WIDTH-1];
                zero_out     <= (bcd_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
`endif
        end
    end

endmodule
